// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU command sequencer and its decoder.
// Unit select codes match in_fun[3:2]; state encoding is private to alu_ctrl.
package alu_pkg;

   localparam int DEF_IN_DATA_WIDTH = 8;
   localparam int DEF_RES_WIDTH     = 16;
   localparam int DEF_TIMEOUT       = 4;
   localparam int NUM_UNITS         = 4;

   typedef enum logic [1:0] {
      UNIT_ARITH = 2'b00,
      UNIT_LOGIC = 2'b01,
      UNIT_CMP   = 2'b10,
      UNIT_SHIFT = 2'b11
   } unit_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_HOLD  = 2'b11
   } alu_ctrl_state_t;

   // Upper two bits of the function code pick the execution unit.
   function automatic unit_sel_t fun_to_unit(input logic [3:0] fun);
      return unit_sel_t'(fun[3:2]);
   endfunction

endpackage

// File: rtl/alu_fun_decoder.sv
// Combinational unit decode: one-hot enables while issuing, plus selection of the
// chosen unit's flag and its result widened to the common result width.
module alu_fun_decoder
   import alu_pkg::*;
#(
   parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
   parameter int RES_WIDTH     = DEF_RES_WIDTH
) (
   input  logic [1:0]               sel,
   input  logic                     issue,
   output logic                     arith_en,
   output logic                     logic_en,
   output logic                     cmp_en,
   output logic                     shift_en,
   input  logic [RES_WIDTH-1:0]     arith_out,
   input  logic [IN_DATA_WIDTH-1:0] logic_out,
   input  logic [1:0]               cmp_out,
   input  logic [IN_DATA_WIDTH-1:0] shift_out,
   input  logic                     arith_flag,
   input  logic                     logic_flag,
   input  logic                     cmp_flag,
   input  logic                     shift_flag,
   output logic                     sel_flag,
   output logic [RES_WIDTH-1:0]     sel_result
);

   logic [NUM_UNITS-1:0] en_vec;
   logic [NUM_UNITS-1:0] flag_vec;

   assign flag_vec = {shift_flag, cmp_flag, logic_flag, arith_flag};

   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_en
      localparam logic [1:0] UNIT_CODE = 2'(gi);
      assign en_vec[gi] = issue && (sel == UNIT_CODE);
   end

   assign {shift_en, cmp_en, logic_en, arith_en} = en_vec;

   // Only the selected unit's flag is visible upstream; the others are masked here.
   assign sel_flag = flag_vec[sel];

   always_comb begin
      sel_result = '0;
      case (unit_sel_t'(sel))
         UNIT_ARITH: sel_result = arith_out;
         UNIT_LOGIC: sel_result = RES_WIDTH'(logic_out);
         UNIT_CMP:   sel_result = RES_WIDTH'(cmp_out);
         UNIT_SHIFT: sel_result = RES_WIDTH'(shift_out);
      endcase
   end

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer in front of the ALU units: accept a command, pulse one unit
// enable, wait (with watchdog) for that unit's flag, then hold the result downstream.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
   parameter int RES_WIDTH     = DEF_RES_WIDTH,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_DATA_WIDTH-1:0] in_a,
   input  logic [IN_DATA_WIDTH-1:0] in_b,
   input  logic [3:0]               in_fun,
   output logic [IN_DATA_WIDTH-1:0] unit_a,
   output logic [IN_DATA_WIDTH-1:0] unit_b,
   output logic [1:0]               unit_fun,
   output logic                     arith_en,
   output logic                     logic_en,
   output logic                     cmp_en,
   output logic                     shift_en,
   input  logic [RES_WIDTH-1:0]     arith_out,
   input  logic [IN_DATA_WIDTH-1:0] logic_out,
   input  logic [1:0]               cmp_out,
   input  logic [IN_DATA_WIDTH-1:0] shift_out,
   input  logic                     arith_flag,
   input  logic                     logic_flag,
   input  logic                     cmp_flag,
   input  logic                     shift_flag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RES_WIDTH-1:0]     out_result,
   output logic [1:0]               out_unit,
   output logic                     out_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   // Timeout fires in the WAIT cycle whose increment would reach TIMEOUT,
   // so exactly TIMEOUT WAIT cycles elapse before an error completion.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   alu_ctrl_state_t            state_reg,  state_next;
   logic [IN_DATA_WIDTH-1:0]   a_reg,      a_next;
   logic [IN_DATA_WIDTH-1:0]   b_reg,      b_next;
   logic [1:0]                 fun_reg,    fun_next;
   unit_sel_t                  sel_reg,    sel_next;
   logic [CNT_W-1:0]           cnt_reg,    cnt_next;
   logic [RES_WIDTH-1:0]       result_reg, result_next;
   unit_sel_t                  unit_reg,   unit_next;
   logic                       err_reg,    err_next;

   logic                       issue;
   logic                       sel_flag;
   logic [RES_WIDTH-1:0]       sel_result;

   alu_fun_decoder #(
      .IN_DATA_WIDTH (IN_DATA_WIDTH),
      .RES_WIDTH     (RES_WIDTH)
   ) u_dec (
      .sel        (sel_reg),
      .issue      (issue),
      .arith_en   (arith_en),
      .logic_en   (logic_en),
      .cmp_en     (cmp_en),
      .shift_en   (shift_en),
      .arith_out  (arith_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag),
      .sel_flag   (sel_flag),
      .sel_result (sel_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         fun_reg    <= '0;
         sel_reg    <= UNIT_ARITH;
         cnt_reg    <= '0;
         result_reg <= '0;
         unit_reg   <= UNIT_ARITH;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         fun_reg    <= fun_next;
         sel_reg    <= sel_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         unit_reg   <= unit_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      fun_next    = fun_reg;
      sel_next    = sel_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      unit_next   = unit_reg;
      err_next    = err_reg;
      issue       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (in_valid) begin
               a_next     = in_a;
               b_next     = in_b;
               fun_next   = in_fun[1:0];
               sel_next   = fun_to_unit(in_fun);
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue      = 1'b1;
            cnt_next   = '0;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // A flag in the watchdog's final cycle still wins over the timeout.
            if (sel_flag) begin
               result_next = sel_result;
               unit_next   = sel_reg;
               err_next    = 1'b0;
               state_next  = ST_HOLD;
            end else if (cnt_reg == CNT_LAST) begin
               result_next = '0;
               unit_next   = sel_reg;
               err_next    = 1'b1;
               state_next  = ST_HOLD;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               err_next   = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign in_ready   = (state_reg == ST_IDLE);
   assign out_valid  = (state_reg == ST_HOLD);
   assign unit_a     = a_reg;
   assign unit_b     = b_reg;
   assign unit_fun   = fun_reg;
   assign out_result = result_reg;
   assign out_unit   = unit_reg;
   assign out_err    = err_reg;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: reactive unit stubs, a driver that pushes expected
// completions from a timing/width model, and a monitor that pops and compares.
module tb_alu_ctrl;

   localparam int W     = 8;
   localparam int RW    = 16;
   localparam int TO    = 4;
   localparam int NEVER = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic [3:0]    in_fun;
   logic [W-1:0]  unit_a, unit_b;
   logic [1:0]    unit_fun;
   logic          arith_en, logic_en, cmp_en, shift_en;
   logic [RW-1:0] arith_out;
   logic [W-1:0]  logic_out, shift_out;
   logic [1:0]    cmp_out;
   logic [3:0]    flag_vec;
   logic          out_valid, out_ready;
   logic [RW-1:0] out_result;
   logic [1:0]    out_unit;
   logic          out_err;

   alu_ctrl #(.IN_DATA_WIDTH(W), .RES_WIDTH(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_fun(in_fun),
      .unit_a(unit_a), .unit_b(unit_b), .unit_fun(unit_fun),
      .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
      .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
      .arith_flag(flag_vec[0]), .logic_flag(flag_vec[1]),
      .cmp_flag(flag_vec[2]), .shift_flag(flag_vec[3]),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_unit(out_unit), .out_err(out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int         unit;
      int         cyc;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] fun;
   } en_exp_t;

   typedef struct {
      logic [15:0] res;
      logic [1:0]  unit;
      logic        err;
      int          rise;
   } out_exp_t;

   en_exp_t  en_q[$];
   out_exp_t exp_q[$];

   int plan_d     = 0;
   bit plan_early = 0;
   bit plan_noise = 0;
   int bp_hold    = 0;
   bit rand_ready = 0;
   bit abort      = 0;

   // Unit stubs: react to an enable, raise the selected flag d+1 cycles later.
   initial begin
      flag_vec = '0;
      #1;
      forever begin
         if ({shift_en, cmp_en, logic_en, arith_en} == 4'b0000) begin
            @(posedge clk); #1;
         end else begin
            int d, u, k;
            bit early, noise;
            d = plan_d; early = plan_early; noise = plan_noise;
            u = arith_en ? 0 : logic_en ? 1 : cmp_en ? 2 : 3;
            k = 0;
            while (k <= d + 1 && k <= TO + 1) begin
               for (int i = 0; i < 4; i++) flag_vec[i] = noise ? 1'b1 : 1'($urandom_range(0, 1));
               flag_vec[u] = (k == 0 && early) || (k == d + 1);
               @(posedge clk); #1;
               k++;
            end
            flag_vec = '0;
         end
      end
   end

   // Downstream ready: forced low for bp_hold valid cycles, else random or always-on.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_hold > 0) begin
            out_ready = 1'b0;
            if (out_valid) bp_hold--;
         end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor: pops enable and completion expectations as the DUT presents them.
   initial begin
      bit prev_valid, just_done;
      en_exp_t e;
      logic [3:0] ev;
      prev_valid = 0; just_done = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ev = {shift_en, cmp_en, logic_en, arith_en};
            if (ev != 4'b0000) begin
               if (en_q.size() == 0) chk("spurious_en", 32'(ev), 32'd0);
               else begin
                  e = en_q.pop_front();
                  chk("enable_onehot", 32'(ev), 32'd1 << e.unit);
                  chk("enable_cycle", cyc, e.cyc);
                  chk("unit_a", 32'(unit_a), 32'(e.a));
                  chk("unit_b", 32'(unit_b), 32'(e.b));
                  chk("unit_fun", 32'(unit_fun), 32'(e.fun));
               end
            end
            if (out_valid) begin
               chk("in_ready_busy", 32'(in_ready), 32'd0);
               if (exp_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
               else begin
                  if (!prev_valid) chk("valid_latency", cyc, exp_q[0].rise);
                  chk("out_result", 32'(out_result), 32'(exp_q[0].res));
                  chk("out_unit", 32'(out_unit), 32'(exp_q[0].unit));
                  chk("out_err", 32'(out_err), 32'(exp_q[0].err));
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     just_done = 1;
                  end
               end
            end else if (just_done) begin
               chk("err_cleared", 32'(out_err), 32'd0);
               chk("ready_after_hs", 32'(in_ready), 32'd1);
               just_done = 0;
            end
            prev_valid = out_valid;
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_unit", 32'(out_unit), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_enables", 32'({shift_en, cmp_en, logic_en, arith_en}), 32'd0);
      chk("rst_unit_a", 32'(unit_a), 32'd0);
      chk("rst_unit_b", 32'(unit_b), 32'd0);
      chk("rst_unit_fun", 32'(unit_fun), 32'd0);
   endtask

   task automatic set_units(input logic [15:0] ar, input logic [7:0] lo,
                            input logic [1:0] cm, input logic [7:0] sh);
      arith_out = ar; logic_out = lo; cmp_out = cm; shift_out = sh;
   endtask

   // Present a command, wait for acceptance, model its completion, wait for the handshake.
   task automatic run_cmd(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                          input int d, input bit early, input bit noise);
      int n, acc;
      en_exp_t  e;
      out_exp_t o;
      if (abort) return;
      plan_d = d; plan_early = early; plan_noise = noise;
      in_a = a; in_b = b; in_fun = fun; in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 60);
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         abort = 1; in_valid = 1'b0; return;
      end
      @(posedge clk); #1;
      acc = cyc;
      e.unit = int'(fun[3:2]); e.cyc = acc; e.a = a; e.b = b; e.fun = fun[1:0];
      en_q.push_back(e);
      case (fun[3:2])
         2'd0:    o.res = arith_out;
         2'd1:    o.res = {8'h00, logic_out};
         2'd2:    o.res = {14'd0, cmp_out};
         default: o.res = {8'h00, shift_out};
      endcase
      o.unit = fun[3:2];
      if (d <= TO - 1) begin
         o.err = 1'b0; o.rise = acc + 2 + d;
      end else begin
         o.err = 1'b1; o.res = '0; o.rise = acc + TO + 1;
      end
      exp_q.push_back(o);
      // Keep a junk command valid while busy: it must not be consumed.
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_fun = 4'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end while (!(out_valid && out_ready) && n < 60);
      if (!(out_valid && out_ready)) begin
         chk("complete_timeout", 32'(out_valid && out_ready), 32'd1);
         abort = 1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic reset_mid_wait();
      int n, acc;
      en_exp_t e;
      if (abort) return;
      plan_d = NEVER; plan_early = 0; plan_noise = 0;
      in_a = 8'h3C; in_b = 8'hC3; in_fun = 4'b0110; in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 60);
      @(posedge clk); #1;
      acc = cyc;
      e.unit = 1; e.cyc = acc; e.a = 8'h3C; e.b = 8'hC3; e.fun = 2'b10;
      en_q.push_back(e);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_reset_state();
      en_q.delete();
      exp_q.delete();
      #2 rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_fun = '0;
      set_units(16'h0, 8'h0, 2'b0, 8'h0);
      #12;
      check_reset_state();
      rst = 1'b1;
      @(posedge clk); #1;

      // Compare, logic zero-extend, arith with all other flags pulsed.
      set_units(16'h1234, 8'h11, 2'b10, 8'h22);
      run_cmd(4'b1010, 8'd5, 8'd3, 0, 0, 0);
      set_units(16'h1234, 8'hA5, 2'b01, 8'h22);
      run_cmd(4'b0100, 8'h80, 8'h7F, 0, 0, 0);
      set_units(16'hFF10, 8'h5A, 2'b11, 8'h99);
      run_cmd(4'b0010, 8'hF0, 8'h10, 0, 0, 1);
      // Backpressure for 5 valid cycles.
      bp_hold = 5;
      set_units(16'h0, 8'h0, 2'b01, 8'h0);
      run_cmd(4'b1001, 8'd1, 8'd2, 1, 0, 0);
      // Timeout, flag on the final WAIT cycle, flag one cycle too late, ISSUE-only flag.
      set_units(16'h0, 8'h0, 2'b00, 8'hEE);
      run_cmd(4'b1101, 8'd9, 8'd4, NEVER, 0, 0);
      run_cmd(4'b1100, 8'd9, 8'd4, TO - 1, 0, 0);
      run_cmd(4'b1110, 8'd9, 8'd4, TO, 0, 0);
      run_cmd(4'b1111, 8'd9, 8'd4, NEVER, 1, 0);
      // Reset in WAIT, then a normal command.
      reset_mid_wait();
      set_units(16'hBEEF, 8'h00, 2'b00, 8'h00);
      run_cmd(4'b0001, 8'd7, 8'd8, 0, 0, 0);

      rand_ready = 1;
      for (int t = 0; t < 60; t++) begin
         int r, d;
         r = $urandom_range(0, 9);
         if (r <= 3)      d = r;
         else if (r == 4) d = TO;
         else if (r == 5) d = NEVER;
         else             d = $urandom_range(0, 2);
         set_units(16'($urandom), 8'($urandom), 2'($urandom), 8'($urandom));
         run_cmd(4'($urandom), 8'($urandom), 8'($urandom), d,
                 $urandom_range(0, 3) == 0, 0);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (5) @(posedge clk);
      chk("queue_drain", 32'(exp_q.size() + en_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
